sdram_wb_arb: RTL and testbench
===============================

Name: sdram_wb_arb

Overview:
- Two-master Wishbone arbiter that shares the single SDRAM Wishbone slave port (25-bit word address, 32-bit data, byte selects) between master 0 (CPU) and master 1 (DMA/video).
- Grants are round-robin and are held for the whole of the granted master's bus cycle (cyc).
- A per-access watchdog terminates hung accesses with an error pulse, so a stalled slave cannot lock either master.

Parameters:
- TIMEOUT, 4096: max cycles a granted stb may wait for s_ack_i before the access is aborted; must be ≥ 2.
- TO_WIDTH, 13: watchdog counter width; must satisfy 2^TO_WIDTH > TIMEOUT.

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_i  in  1  asynchronous, active-high reset
- m0_adr_i  in  25  master 0 word address
- m0_dat_i  in  32  master 0 write data
- m0_dat_o  out  32  master 0 read data
- m0_we_i  in  1  master 0 write enable
- m0_sel_i  in  4  master 0 byte selects
- m0_stb_i  in  1  master 0 strobe
- m0_cyc_i  in  1  master 0 cycle
- m0_ack_o  out  1  master 0 acknowledge
- m0_err_o  out  1  master 0 timeout error pulse
- m1_*: identical set to m0_* for master 1
- s_adr_o  out  25  to SDRAM slave
- s_dat_o  out  32  to SDRAM slave
- s_dat_i  in  32  from SDRAM slave
- s_we_o  out  1  to SDRAM slave
- s_sel_o  out  4  to SDRAM slave
- s_stb_o  out  1  to SDRAM slave
- s_cyc_o  out  1  to SDRAM slave
- s_ack_i  in  1  from SDRAM slave
- gnt_o  out  2  one-hot grant (debug/status)

Behaviour:
Clock and reset:
- One clock: wb_clk_i.
- wb_rst_i is asynchronous and active-high.

Reset values:
- state=IDLE, gnt_o=00, last=1 (so master 0 wins the first contention), watchdog=0.
- All registered outputs 0.

State machine: IDLE, GNT0, GNT1, ABORT.
- IDLE, only m0_cyc_i: next GNT0.
- IDLE, only m1_cyc_i: next GNT1.
- IDLE, both m0_cyc_i and m1_cyc_i: grant the master ≠ last.
- Entering GNTx: set last=x.
- Arbitration decision takes 1 cycle. IDLE never drives s_cyc_o/s_stb_o.
- GNTx, mx_cyc_i low: return to IDLE. No back-to-back re-grant in the same cycle; minimum 1 IDLE cycle between grants.
- GNTx, watchdog reaches TIMEOUT: go to ABORT.
- ABORT: s_cyc_o=s_stb_o=0. Stay until mx_cyc_i drops, then go to IDLE.

Datapath, combinational mux on the registered grant:
- In GNTx: s_adr_o, s_dat_o, s_we_o, s_sel_o, s_stb_o, s_cyc_o = master x signals.
- Otherwise: all s_* outputs 0.
- mx_ack_o = s_ack_i && state==GNTx. The non-granted master never sees ack.
- m0_dat_o = m1_dat_o = s_dat_i (shared); data is valid only when the corresponding ack is high.

Watchdog:
- Counts while in GNTx with mx_stb_i=1 and s_ack_i=0.
- Clears on s_ack_i, on stb low, and on any state change.
- On the cycle the count equals TIMEOUT-1 with no ack: mx_err_o pulses high for exactly 1 cycle, state goes to ABORT.
- ack and err are never both high for a master in the same cycle. An ack on the timeout cycle wins, and no err is raised.

Boundary conditions:
- Master drops cyc with stb high and no ack: the grant is released anyway. The slave sees cyc fall and the access is discarded.
- A new request from the other master during GNTx waits. There is no preemption.
- Reset mid-access: all outputs go to 0 immediately (asynchronous). The SDRAM controller is reset by the same wb_rst_i.
- The slave acks one access per stb and may hold ack for 1 cycle only. The arbiter does not register ack, so it adds no latency beyond the grant cycle.

Test Plan:
- Single master: m0 read of adr 0x0000100 after reset, slave returns 0xCAFEF00D. Expect gnt_o=01 one cycle after m0_cyc_i rises, m0_ack_o with m0_dat_o=0xCAFEF00D, m1_ack_o never high.
- Simultaneous request: m0 and m1 both raise cyc in the same cycle from reset. Expect m0 granted first, m1 granted after m0 drops cyc plus 1 IDLE cycle. Repeat the contention: m1 now wins (round-robin).
- Hold: m1 performs 3 back-to-back writes (0x11111111, 0x22222222, 0x33333333, sel=1111) within one cyc while m0 requests. Expect all 3 forwarded to the slave with correct adr/dat/sel before gnt_o changes to 01.
- Timeout: TIMEOUT=16, slave never acks an m0 read. Expect m0_err_o high exactly 1 cycle after 16 cycles of stb, s_stb_o=0 afterwards, return to IDLE when m0 drops cyc, and m1 served normally afterward.
- Ack at the limit: slave acks on the timeout cycle. Expect m0_ack_o=1 and m0_err_o=0.
- Async reset mid-write (GNT1, s_stb_o=1): expect s_cyc_o, s_stb_o and gnt_o=0 before the next clock edge, and the first post-reset contention grants m0.

Source files
------------

// File: rtl/sdram_wb_arb.sv
// Two-master round-robin Wishbone arbiter for the shared SDRAM slave port.
// Ports: wb_clk_i/wb_rst_i, m0_*/m1_* master ports, s_* slave port, gnt_o.
module sdram_wb_arb #(
  parameter int TIMEOUT  = 4096,
  parameter int TO_WIDTH = 13
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [24:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_stb_i,
  input  logic        m0_cyc_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic [24:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_stb_i,
  input  logic        m1_cyc_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [24:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic        s_stb_o,
  output logic        s_cyc_o,
  input  logic        s_ack_i,
  output logic [1:0]  gnt_o
);

  typedef enum logic [1:0] {
    IDLE, GNT0, GNT1, ABORT
  } state_t;

  state_t              state;
  logic                last;
  logic [TO_WIDTH-1:0] wd;

  // 'last' always names the master that owns GNTx/ABORT
  logic g_cyc, g_stb, granted, to_hit;

  assign g_cyc   = last ? m1_cyc_i : m0_cyc_i;
  assign g_stb   = last ? m1_stb_i : m0_stb_i;
  assign granted = (state == GNT0) || (state == GNT1);

  // ack on the limit cycle wins over the timeout
  assign to_hit = granted && g_cyc && g_stb && !s_ack_i
                  && (wd == TO_WIDTH'(TIMEOUT - 1));

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      last  <= 1'b1;
      wd    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          wd <= '0;
          if (m0_cyc_i && (!m1_cyc_i || last)) begin
            state <= GNT0;
            last  <= 1'b0;
          end else if (m1_cyc_i) begin
            state <= GNT1;
            last  <= 1'b1;
          end
        end
        GNT0, GNT1: begin
          if (!g_cyc) begin
            state <= IDLE;
            wd    <= '0;
          end else if (to_hit) begin
            state <= ABORT;
            wd    <= '0;
          end else if (g_stb && !s_ack_i) begin
            wd <= wd + 1'b1;
          end else begin
            wd <= '0;
          end
        end
        ABORT: begin
          wd <= '0;
          if (!g_cyc) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_stb_o = 1'b0;
    s_cyc_o = 1'b0;
    gnt_o   = 2'b00;
    if (state == GNT0) begin
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
      s_we_o  = m0_we_i;
      s_sel_o = m0_sel_i;
      s_stb_o = m0_stb_i;
      s_cyc_o = m0_cyc_i;
      gnt_o   = 2'b01;
    end else if (state == GNT1) begin
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
      s_we_o  = m1_we_i;
      s_sel_o = m1_sel_i;
      s_stb_o = m1_stb_i;
      s_cyc_o = m1_cyc_i;
      gnt_o   = 2'b10;
    end
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = s_ack_i && (state == GNT0);
  assign m1_ack_o = s_ack_i && (state == GNT1);
  assign m0_err_o = to_hit && (state == GNT0);
  assign m1_err_o = to_hit && (state == GNT1);

endmodule

// File: tb/tb_sdram_wb_arb.sv
// Bench for sdram_wb_arb: directed stimulus, spec-level model checked
// every cycle, plus literal expectations for each scenario.
module tb_sdram_wb_arb;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [24:0] m0_adr = '0, m1_adr = '0;
  logic [31:0] m0_dat = '0, m1_dat = '0;
  logic [31:0] m0_q, m1_q;
  logic        m0_we = 0, m1_we = 0;
  logic [3:0]  m0_sel = '0, m1_sel = '0;
  logic        m0_stb = 0, m1_stb = 0;
  logic        m0_cyc = 0, m1_cyc = 0;
  logic        m0_ack, m1_ack, m0_err, m1_err;
  logic [24:0] s_adr;
  logic [31:0] s_wdat;
  logic [31:0] s_rdat = '0;
  logic        s_we, s_stb, s_cyc;
  logic [3:0]  s_sel;
  logic        s_ack = 0;
  logic [1:0]  gnt;

  int checks = 0;
  int errors = 0;

  sdram_wb_arb #(.TIMEOUT(TO), .TO_WIDTH(5)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_dat_o(m0_q),
    .m0_we_i(m0_we), .m0_sel_i(m0_sel), .m0_stb_i(m0_stb),
    .m0_cyc_i(m0_cyc), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_dat_o(m1_q),
    .m1_we_i(m1_we), .m1_sel_i(m1_sel), .m1_stb_i(m1_stb),
    .m1_cyc_i(m1_cyc), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
    .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_dat_i(s_rdat),
    .s_we_o(s_we), .s_sel_o(s_sel), .s_stb_o(s_stb),
    .s_cyc_o(s_cyc), .s_ack_i(s_ack), .gnt_o(gnt)
  );

  always #5 clk = ~clk;

  // Model: owner (-1 none), aborted flag, last winner, stalled-stb count
  int own = -1;
  bit ab = 0;
  int lastw = 1;
  int waited = 0;
  logic [133:0] ev, av;

  always @(negedge clk) begin
    bit g, c, s, er;
    if (rst) begin
      own = -1; ab = 0; lastw = 1; waited = 0;
    end
    g = (own >= 0) && !ab;
    c = (own == 1) ? m1_cyc : m0_cyc;
    s = (own == 1) ? m1_stb : m0_stb;
    er = g && c && s && !s_ack && (waited == TO - 1);
    ev = '0;
    if (g && own == 0)
      ev[133:64] = {m0_adr, m0_dat, m0_we, m0_sel, m0_stb, m0_cyc,
                    s_ack, er, 1'b0, 1'b0, 2'b01};
    else if (g && own == 1)
      ev[133:64] = {m1_adr, m1_dat, m1_we, m1_sel, m1_stb, m1_cyc,
                    1'b0, 1'b0, s_ack, er, 2'b10};
    ev[63:0] = {s_rdat, s_rdat};
    av = {s_adr, s_wdat, s_we, s_sel, s_stb, s_cyc,
          m0_ack, m0_err, m1_ack, m1_err, gnt, m0_q, m1_q};
    checks++;
    if (av !== ev) begin
      errors++;
      $display("FAIL model t=%0t got %h want %h", $time, av, ev);
    end
    if (!rst) begin
      if (own < 0) begin
        if (m0_cyc && m1_cyc) own = 1 - lastw;
        else if (m0_cyc) own = 0;
        else if (m1_cyc) own = 1;
        if (own >= 0) lastw = own;
        waited = 0;
      end else if (!c) begin
        own = -1; ab = 0; waited = 0;
      end else if (ab) begin
        waited = 0;
      end else if (er) begin
        ab = 1; waited = 0;
      end else begin
        waited = (s && !s_ack) ? waited + 1 : 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #3 rst = 1;
    tick();
    rst = 0;
  endtask

  int errcnt, errat;

  initial begin
    #30000;
    $display("FAIL watchdog simulation time limit");
    $fatal(1, "timeout");
  end

  initial begin
    tick(); tick();
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_cyc", 32'(s_cyc), 0);
    rst = 0;

    // single master read
    m0_cyc = 1; m0_stb = 1; m0_adr = 25'h0000100; m0_sel = 4'hF;
    #1 chk("t1_idle_gnt", 32'(gnt), 0);
    chk("t1_idle_stb", 32'(s_stb), 0);
    tick();
    chk("t1_gnt", 32'(gnt), 32'h1);
    chk("t1_adr", 32'(s_adr), 32'h100);
    s_ack = 1; s_rdat = 32'hCAFEF00D;
    #1 chk("t1_ack", 32'(m0_ack), 1);
    chk("t1_dat", m0_q, 32'hCAFEF00D);
    chk("t1_m1ack", 32'(m1_ack), 0);
    tick();
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    tick();
    chk("t1_release", 32'(gnt), 0);

    // contention from reset, then round-robin
    reset_pulse();
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    m1_adr = 25'h0000200;
    tick();
    chk("t2_first", 32'(gnt), 32'h1);
    s_ack = 1;
    tick();
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    tick();
    chk("t2_gap", 32'(gnt), 0);
    m0_cyc = 1; m0_stb = 1;
    tick();
    chk("t2_rr_m1", 32'(gnt), 32'h2);

    // m1 holds grant for 3 writes while m0 waits
    m1_we = 1; m1_sel = 4'hF;
    for (int i = 0; i < 3; i++) begin
      m1_adr = 25'h0000300 + 25'(i);
      m1_dat = 32'h11111111 * (i + 1);
      s_ack = 1;
      #1;
      chk("t3_adr", 32'(s_adr), 32'h300 + i);
      chk("t3_dat", s_wdat, 32'h11111111 * (i + 1));
      chk("t3_sel", 32'(s_sel), 32'hF);
      chk("t3_ack", 32'(m1_ack), 1);
      chk("t3_hold", 32'(gnt), 32'h2);
      tick();
    end
    s_ack = 0; m1_cyc = 0; m1_stb = 0; m1_we = 0;
    tick();
    chk("t3_gap", 32'(gnt), 0);
    tick();
    chk("t3_m0", 32'(gnt), 32'h1);
    s_ack = 1;
    tick();
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    tick();

    // timeout on a never-acked m0 read
    m0_cyc = 1; m0_stb = 1; m0_we = 0;
    tick();
    errcnt = 0; errat = -1;
    for (int i = 0; i < 20; i++) begin
      if (m0_err) begin
        errcnt++;
        if (errat < 0) errat = i;
      end
      if (i == 10) begin m1_cyc = 1; m1_stb = 1; end
      tick();
    end
    chk("t4_errcnt", 32'(errcnt), 1);
    chk("t4_errat", 32'(errat), TO - 1);
    chk("t4_stb", 32'(s_stb), 0);
    chk("t4_cyc", 32'(s_cyc), 0);
    chk("t4_m1wait", 32'(gnt), 0);
    m0_cyc = 0; m0_stb = 0;
    tick();
    chk("t4_idle", 32'(gnt), 0);
    tick();
    chk("t4_m1", 32'(gnt), 32'h2);
    s_ack = 1;
    #1 chk("t4_m1ack", 32'(m1_ack), 1);
    tick();
    s_ack = 0; m1_cyc = 0; m1_stb = 0;
    tick();

    // ack exactly on the limit cycle
    m0_cyc = 1; m0_stb = 1;
    tick();
    for (int i = 0; i < TO - 1; i++) tick();
    s_ack = 1;
    #1 chk("t5_ack", 32'(m0_ack), 1);
    chk("t5_err", 32'(m0_err), 0);
    tick();
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    tick();

    // async reset during an m1 write
    m1_cyc = 1; m1_stb = 1; m1_we = 1;
    m1_adr = 25'h0000400; m1_dat = 32'hDEADBEEF;
    tick();
    chk("t6_pre", 32'(s_stb), 1);
    m0_cyc = 1; m0_stb = 1;
    #1 rst = 1;
    #1 chk("t6_cyc", 32'(s_cyc), 0);
    chk("t6_stb", 32'(s_stb), 0);
    chk("t6_gnt", 32'(gnt), 0);
    tick();
    rst = 0;
    tick();
    chk("t6_post", 32'(gnt), 32'h1);
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
